// File: rtl/edge_pkg.sv
// Frame geometry, luma weights and shared types for the grayscale and Sobel stages.
package edge_pkg;

    localparam int unsigned IMG_WIDTH    = 720;
    localparam int unsigned IMG_HEIGHT   = 540;
    localparam int unsigned FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;

    // Luma weights sum to 256 so the weighted sum reduces with a plain >> 8
    localparam logic [7:0] W_R = 8'd77;
    localparam logic [7:0] W_G = 8'd150;
    localparam logic [7:0] W_B = 8'd29;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {IDLE, STREAM} trk_state_t;

endpackage

// File: rtl/rgb2gray_core.sv
// Combinational RGB to 8-bit gray conversion.
// GRAY_WEIGHTED_EN selects luma weighting; otherwise the plain channel average is used.
module rgb2gray_core
    import edge_pkg::*;
(
    input  rgb_t       pix,
    output logic [7:0] gray
);

`ifdef GRAY_WEIGHTED_EN
    logic [15:0] wsum;

    always_comb begin
        wsum = {8'd0, W_R} * {8'd0, pix.r}
             + {8'd0, W_G} * {8'd0, pix.g}
             + {8'd0, W_B} * {8'd0, pix.b};
        gray = 8'(wsum >> 8);
    end
`else
    logic [9:0] sum;

    always_comb begin
        sum  = {2'b00, pix.r} + {2'b00, pix.g} + {2'b00, pix.b};
        gray = 8'(sum / 10'd3);
    end
`endif

endmodule

// File: rtl/grayscale.sv
// Two-stage RGB-to-gray pipeline between FWFT FIFOs with per-frame pixel counting.
// Conversion formula is selected by the GRAY_WEIGHTED_EN macro inside rgb2gray_core.
module grayscale
    import edge_pkg::*;
#(
    parameter int unsigned WIDTH        = IMG_WIDTH,
    parameter int unsigned HEIGHT       = IMG_HEIGHT,
    parameter int unsigned FRAME_PIXELS = WIDTH * HEIGHT
) (
    input  logic        clock,
    input  logic        reset,
    output logic        in_rd_en,
    input  logic        in_empty,
    input  logic [23:0] in_dout,
    output logic        out_wr_en,
    input  logic        out_full,
    output logic [7:0]  out_din,
    output logic        frame_done
);

    localparam logic [18:0] LAST_PIX = 19'(FRAME_PIXELS - 1);

    logic       s1_valid;
    logic       s2_valid;
    rgb_t       s1_pix;
    logic [7:0] gray_reg;
    logic [7:0] gray_next;
    logic       adv1;
    logic       adv2;
    logic [18:0] pix_cnt;
    trk_state_t state;

    // Reset gates both strobes so nothing moves through the FIFOs in the reset cycle
    always_comb begin
        adv2      = !s2_valid || !out_full;
        adv1      = !s1_valid || adv2;
        in_rd_en  = !in_empty && adv1 && !reset;
        out_wr_en = s2_valid && !out_full && !reset;
        out_din   = out_wr_en ? gray_reg : '0;
    end

    rgb2gray_core u_core (
        .pix  (s1_pix),
        .gray (gray_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_pix   <= '0;
            gray_reg <= '0;
        end else begin
            if (in_rd_en) begin
                s1_pix   <= rgb_t'(in_dout);
                s1_valid <= 1'b1;
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                gray_reg <= gray_next;
            end
        end
    end

    // Frame tracker: the state is observational only and never gates data flow
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_cnt    <= '0;
            frame_done <= 1'b0;
            state      <= IDLE;
        end else begin
            frame_done <= 1'b0;
            if (out_wr_en) begin
                if (pix_cnt == LAST_PIX) begin
                    pix_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 19'd1;
                end
            end
            case (state)
                IDLE:    if (in_rd_en) state <= STREAM;
                STREAM:  if (out_wr_en && pix_cnt == LAST_PIX) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grayscale.sv
// Randomised and directed bench for grayscale, using a FIFO/queue model of the pipeline.
// Build with +define+GRAY_WEIGHTED_EN to check the weighted formula.
module tb_grayscale;

    localparam int unsigned FP = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_rd_en;
    logic        in_empty;
    logic [23:0] in_dout;
    logic        out_wr_en;
    logic        out_full;
    logic [7:0]  out_din;
    logic        frame_done;

    grayscale #(.FRAME_PIXELS(FP)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_rd_en   (in_rd_en),
        .in_empty   (in_empty),
        .in_dout    (in_dout),
        .out_wr_en  (out_wr_en),
        .out_full   (out_full),
        .out_din    (out_din),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    logic [23:0] src_q[$];
    int exp_q[$];
    int pushes   = 0;
    int fd_exp   = 0;
    int fd_seen  = 0;
    int rd_count = 0;
    int wr_count = 0;
    int last_din = 0;
    int rd_cyc   = 0;
    int wr_cyc   = 0;
    int cyc      = 0;

    function automatic int ref_gray(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
`ifdef GRAY_WEIGHTED_EN
        return (77 * r + 150 * g + 29 * b) / 256;
`else
        return (r + g + b) / 3;
`endif
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic monitor();
        if (reset) begin
            check("rst_rd_en", int'(in_rd_en), 0);
            check("rst_wr_en", int'(out_wr_en), 0);
            check("rst_din", int'(out_din), 0);
            exp_q.delete();
            pushes = 0;
            fd_exp = 0;
            return;
        end
        check("frame_done", int'(frame_done), fd_exp);
        if (frame_done) fd_seen++;
        fd_exp = 0;
        // Pipeline holds at most two pixels; a third pop is allowed only if one leaves
        check("rd_en", int'(in_rd_en), int'(!in_empty && (exp_q.size() < 2 || !out_full)));
        if (out_wr_en) begin
            wr_count++;
            wr_cyc   = cyc;
            last_din = int'(out_din);
            check("wr_when_full", int'(out_full), 0);
            if (exp_q.size() == 0) begin
                check("spurious_wr", int'(out_wr_en), 0);
            end else begin
                check("gray", int'(out_din), exp_q.pop_front());
                pushes++;
                if (pushes % FP == 0) fd_exp = 1;
            end
        end else begin
            check("din_idle", int'(out_din), 0);
        end
        if (in_rd_en) begin
            rd_count++;
            rd_cyc = cyc;
            if (src_q.size() != 0) exp_q.push_back(ref_gray(src_q.pop_front()));
        end
    endtask

    task automatic step(input bit rst, input bit full, input bit gate);
        @(posedge clock);
        #1;
        reset    = rst;
        out_full = full;
        in_empty = gate || (src_q.size() == 0);
        in_dout  = (src_q.size() != 0) ? src_q[0] : '0;
        @(negedge clock);
        cyc++;
        monitor();
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || src_q.size() != 0); i++) step(1'b0, 1'b0, 1'b0);
        check("drain_done", exp_q.size() + src_q.size(), 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    logic [23:0] dir_px  [5] = '{24'hFF0000, 24'hFFFFFF, 24'h000000, 24'h808080, 24'h00FF00};
`ifdef GRAY_WEIGHTED_EN
    int          dir_exp [5] = '{76, 255, 0, 128, 149};
`else
    int          dir_exp [5] = '{85, 255, 0, 128, 85};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        out_full = 1'b0;
        in_empty = 1'b1;
        in_dout  = '0;
        repeat (3) step(1'b1, 1'b0, 1'b0);

        // Directed pixels, one at a time through an idle pipeline
        for (int i = 0; i < 5; i++) begin
            src_q.push_back(dir_px[i]);
            wr_count = 0;
            for (int k = 0; k < 10 && wr_count == 0; k++) step(1'b0, 1'b0, 1'b0);
            check("direct_seen", wr_count, 1);
            check("direct_val", last_din, dir_exp[i]);
            if (i == 0) check("latency", wr_cyc - rd_cyc, 2);
        end
        drain();

        // Back-pressure: out_full high for cycles 3..8 of a 10-pixel burst
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) src_q.push_back(24'($urandom));
        rd_count = 0;
        wr_count = 0;
        for (int c = 1; c <= 20; c++) begin
            step(1'b0, (c >= 3 && c <= 8), 1'b0);
            if (c == 8) begin
                check("bp_pops", rd_count, 2);
                check("bp_rd_low", int'(in_rd_en), 0);
                check("bp_no_push", wr_count, 0);
            end
        end
        drain();
        check("bp_all_pushed", wr_count, 10);

        // Frame wrap: 9 pixels back-to-back, then 3 more to finish the third frame
        step(1'b1, 1'b0, 1'b0);
        fd_seen  = 0;
        wr_count = 0;
        for (int i = 0; i < 9; i++) src_q.push_back(24'($urandom));
        drain();
        check("frame_pulses", fd_seen, 2);
        check("frame_pushes", wr_count, 9);
        for (int i = 0; i < 3; i++) src_q.push_back(24'($urandom));
        drain();
        check("frame_resume", fd_seen, 3);

        // Reset after 3 of 4 pixels of a frame
        step(1'b1, 1'b0, 1'b0);
        wr_count = 0;
        for (int i = 0; i < 4; i++) src_q.push_back(24'($urandom));
        for (int k = 0; k < 20 && wr_count < 3; k++) step(1'b0, 1'b0, 1'b0);
        check("mid_pushes", wr_count, 3);
        step(1'b1, 1'b0, 1'b0);
        src_q.delete();
        fd_seen  = 0;
        wr_count = 0;
        for (int i = 0; i < 4; i++) src_q.push_back(24'($urandom));
        drain();
        check("mid_frame_done", fd_seen, 1);
        check("mid_next_pushes", wr_count, 4);

        // Empty toggling every cycle halves throughput
        rd_count = 0;
        wr_count = 0;
        for (int i = 0; i < 8; i++) src_q.push_back(24'($urandom));
        for (int c = 0; c < 16; c++) step(1'b0, 1'b0, c[0]);
        check("toggle_pops", rd_count, 8);
        drain();
        check("toggle_pushes", wr_count, 8);

        // Random traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            if (src_q.size() < 4) begin
                for (int j = 0; j < int'($urandom_range(1, 6)); j++) src_q.push_back(24'($urandom));
            end
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
